// File: rtl/led_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_arb_pkg
// Purpose : Shared constants and types for the LED bank arbiter slice.
//           c_LED_W_DEF - default LEDR / SW width of the board
//           arb_state_t - arbiter FSM encoding (IDLE: no owner, OWN: owned)
// Rev     : 1.0  initial release
// ============================================================================
package led_arb_pkg;

  localparam int c_LED_W_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/led_bank_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin priority picker. Scans req starting at
//           index ptr and wrapping at N; reports the first set bit.
// Ports   : req   in  N   request vector
//           ptr   in  IW  index with highest priority
//           found out 1   some request bit is set
//           idx   out IW  index of the winning request (0 when !found)
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : led_bank_arbiter
// Purpose : Shares the board LEDR bank between REQ_N requesters using
//           round-robin arbitration. With no owner, LEDR echoes the
//           synchronized switches.
// Ports   : clk       in  1              system clock
//           rst_n     in  1              asynchronous active-low reset
//           sw        in  LED_W          raw board switches (asynchronous)
//           req       in  REQ_N          per-requester ownership request
//           req_data  in  REQ_N x LED_W  LED pattern per requester
//           gnt       out REQ_N          one-hot grant (registered)
//           owner_vld out 1              some requester owns the bank
//           owner_id  out clog2(REQ_N)   current / last owner index
//           ledr      out LED_W          registered LED drive
// Config  : LED_ARB_TIMEOUT_EN - when defined, an owner still requesting
//           after MAX_OWN owned edges is revoked and masked until it has
//           been seen with req low.
// Rev     : 1.0  initial release
// ============================================================================
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int REQ_N   = 3,
  parameter int LED_W   = c_LED_W_DEF,
  parameter int MAX_OWN = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LED_W-1:0]              sw,
  input  logic [REQ_N-1:0]              req,
  input  logic [REQ_N-1:0][LED_W-1:0]   req_data,
  output logic [REQ_N-1:0]              gnt,
  output logic                          owner_vld,
  output logic [$clog2(REQ_N)-1:0]      owner_id,
  output logic [LED_W-1:0]              ledr
);

  localparam int c_IW = $clog2(REQ_N);

  if (REQ_N < 2 || REQ_N > 8 || MAX_OWN < 1) begin : g_param_check
    $error("led_bank_arbiter: REQ_N must be 2..8 and MAX_OWN >= 1");
  end

  arb_state_t       r_state, w_state_nxt;
  logic [LED_W-1:0] r_sw_m, r_sw_s;
  logic [c_IW-1:0]  r_ptr, w_ptr_nxt, w_ptr_hand, w_pick_ptr, w_pick_idx, w_id_nxt;
  logic [REQ_N-1:0] w_req_eff, w_pick_req, w_pick_oh, w_owner_oh, w_gnt_nxt;
  logic             w_pick_found, w_release, w_timeout, w_vld_nxt;
  logic [LED_W-1:0] w_ledr_nxt;

  // One-hot forms of the picker result and of the current owner.
  always_comb begin
    w_pick_oh              = '0;
    w_pick_oh[w_pick_idx]  = 1'b1;
    w_owner_oh             = '0;
    w_owner_oh[owner_id]   = 1'b1;
  end

  // Pointer just past the current owner; becomes rr_ptr on release.
  assign w_ptr_hand = (owner_id == c_IW'(REQ_N - 1)) ? '0 : owner_id + 1'b1;
  assign w_release  = ~req[owner_id] | w_timeout;

  // A single picker serves both the IDLE grant and the release hand-off.
  // During hand-off the outgoing owner is excluded so a timed-out owner
  // cannot win its own slot back.
  assign w_pick_ptr = (r_state == OWN) ? w_ptr_hand : r_ptr;
  assign w_pick_req = (r_state == OWN) ? (w_req_eff & ~w_owner_oh) : w_req_eff;

  rr_pick #(
    .N  (REQ_N),
    .IW (c_IW)
  ) u_rr_pick (
    .req   (w_pick_req),
    .ptr   (w_pick_ptr),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

`ifdef LED_ARB_TIMEOUT_EN
  localparam int c_CW = $clog2(MAX_OWN + 1);

  logic [c_CW-1:0]  r_own_cnt;
  logic [REQ_N-1:0] r_mask;
  logic             w_grant;

  assign w_grant   = w_pick_found && ((r_state == IDLE) || w_release);
  assign w_timeout = (r_state == OWN) && (r_own_cnt == c_CW'(MAX_OWN - 1)) && req[owner_id];
  assign w_req_eff = req & ~r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own_cnt <= '0;
      r_mask    <= '0;
    end else begin
      if (w_grant)
        r_own_cnt <= '0;
      else if (r_state == OWN)
        r_own_cnt <= r_own_cnt + 1'b1;
      // A mask bit survives only while its request stays high.
      r_mask <= (r_mask & req) | (w_timeout ? w_owner_oh : '0);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_req_eff = req;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = gnt;
    w_vld_nxt   = owner_vld;
    w_id_nxt    = owner_id;
    w_ptr_nxt   = r_ptr;
    w_ledr_nxt  = r_sw_s;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = OWN;
          w_gnt_nxt   = w_pick_oh;
          w_vld_nxt   = 1'b1;
          w_id_nxt    = w_pick_idx;
          w_ledr_nxt  = req_data[w_pick_idx];
        end
      end
      OWN: begin
        if (w_release) begin
          w_ptr_nxt = w_ptr_hand;
          if (w_pick_found) begin
            w_gnt_nxt  = w_pick_oh;
            w_id_nxt   = w_pick_idx;
            w_ledr_nxt = req_data[w_pick_idx];
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_vld_nxt   = 1'b0;
          end
        end else begin
          w_ledr_nxt = req_data[owner_id];
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_m    <= '0;
      r_sw_s    <= '0;
      r_ptr     <= '0;
      gnt       <= '0;
      owner_vld <= 1'b0;
      owner_id  <= '0;
      ledr      <= '0;
    end else begin
      r_sw_m    <= sw;
      r_sw_s    <= r_sw_m;
      r_ptr     <= w_ptr_nxt;
      gnt       <= w_gnt_nxt;
      owner_vld <= w_vld_nxt;
      owner_id  <= w_id_nxt;
      ledr      <= w_ledr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_bank_arbiter
// Purpose : Self-checking bench for led_bank_arbiter (REQ_N=3, LED_W=10,
//           MAX_OWN=8). Directed vector table plus hand-written sequences
//           for reset, async reset mid-ownership, timeout, and a random run
//           against a small arbitration model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_led_bank_arbiter;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [9:0]          sw;
  logic [2:0]          req;
  logic [2:0][9:0]     req_data;
  logic [2:0]          gnt;
  logic                owner_vld;
  logic [1:0]          owner_id;
  logic [9:0]          ledr;

  int n_checks = 0;
  int n_fail   = 0;

  led_bank_arbiter #(
    .REQ_N   (3),
    .LED_W   (10),
    .MAX_OWN (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .owner_vld (owner_vld),
    .owner_id  (owner_id),
    .ledr      (ledr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [9:0] sw;
    logic [9:0] d0, d1, d2;
    logic [2:0] gnt;
    logic       vld;
    logic [1:0] id;
    logic [9:0] ledr;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0][9:0] saved;
    logic [2:0]      r;
    bit              m_vld;
    int              m_id, m_ptr;

    //              req     sw      d0      d1      d2      gnt    vld  id    ledr
    tbl[0]  = '{3'b010, 10'h2A5, 10'h0F0, 10'h155, 10'h3C3, 3'b010, 1'b1, 2'd1, 10'h155};
    tbl[1]  = '{3'b010, 10'h000, 10'h0F0, 10'h155, 10'h3C3, 3'b010, 1'b1, 2'd1, 10'h155};
    tbl[2]  = '{3'b010, 10'h000, 10'h0F0, 10'h0AA, 10'h3C3, 3'b010, 1'b1, 2'd1, 10'h0AA};
    tbl[3]  = '{3'b111, 10'h3FF, 10'h001, 10'h0AA, 10'h3C3, 3'b010, 1'b1, 2'd1, 10'h0AA};
    tbl[4]  = '{3'b101, 10'h3FF, 10'h0F0, 10'h0AA, 10'h3C3, 3'b100, 1'b1, 2'd2, 10'h3C3};
    tbl[5]  = '{3'b101, 10'h3FF, 10'h0F0, 10'h0AA, 10'h111, 3'b100, 1'b1, 2'd2, 10'h111};
    tbl[6]  = '{3'b001, 10'h3FF, 10'h0F0, 10'h0AA, 10'h111, 3'b001, 1'b1, 2'd0, 10'h0F0};
    tbl[7]  = '{3'b000, 10'h3FF, 10'h0F0, 10'h0AA, 10'h111, 3'b000, 1'b0, 2'd0, 10'h3FF};
    tbl[8]  = '{3'b000, 10'h3FF, 10'h0F0, 10'h0AA, 10'h111, 3'b000, 1'b0, 2'd0, 10'h3FF};
    tbl[9]  = '{3'b011, 10'h3FF, 10'h0F0, 10'h0AA, 10'h111, 3'b010, 1'b1, 2'd1, 10'h0AA};
    tbl[10] = '{3'b001, 10'h3FF, 10'h0F0, 10'h0AA, 10'h111, 3'b001, 1'b1, 2'd0, 10'h0F0};
    tbl[11] = '{3'b000, 10'h3FF, 10'h0F0, 10'h0AA, 10'h111, 3'b000, 1'b0, 2'd0, 10'h3FF};

    // ---- Reset values and switch echo latency ----
    rst_n    = 1'b0;
    sw       = 10'h2A5;
    req      = '0;
    req_data = '0;
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_vld", 32'(owner_vld), 32'h0);
    chk("reset_id", 32'(owner_id), 32'h0);
    chk("reset_ledr", 32'(ledr), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("echo_edge2_ledr", 32'(ledr), 32'h0);
    step();
    chk("echo_edge3_ledr", 32'(ledr), 32'h2A5);
    chk("echo_gnt", 32'(gnt), 32'h0);
    chk("echo_vld", 32'(owner_vld), 32'h0);

    // ---- Directed table: grant, hold, hand-off, release ----
    for (int i = 0; i < 12; i++) begin
      req      = tbl[i].req;
      sw       = tbl[i].sw;
      req_data = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
      step();
      chk($sformatf("row%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d_vld", i), 32'(owner_vld), 32'(tbl[i].vld));
      chk($sformatf("row%0d_id", i), 32'(owner_id), 32'(tbl[i].id));
      chk($sformatf("row%0d_ledr", i), 32'(ledr), 32'(tbl[i].ledr));
    end

    // ---- Async reset mid-ownership; rr_ptr (now 1) must return to 0 ----
    req = 3'b010;
    step();
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_vld", 32'(owner_vld), 32'h0);
    chk("async_rst_ledr", 32'(ledr), 32'h0);
    chk("async_rst_id", 32'(owner_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 3'b101;
    step();
    chk("post_rst_ptr_gnt", 32'(gnt), 32'h1);
    chk("post_rst_ledr", 32'(ledr), 32'h0F0);

    // ---- Ownership limit ----
    req = 3'b000;
    step();
    req = 3'b001;
    step();
    chk("own_grant", 32'(gnt), 32'h1);
`ifdef LED_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("own_hold%0d", k), 32'(gnt), 32'h1);
    end
    step();
    chk("timeout_revoke_gnt", 32'(gnt), 32'h0);
    chk("timeout_revoke_vld", 32'(owner_vld), 32'h0);
    step();
    chk("masked_hold1", 32'(gnt), 32'h0);
    step();
    chk("masked_hold2", 32'(gnt), 32'h0);
    req = 3'b000;
    step();
    chk("unmask_low", 32'(gnt), 32'h0);
    req = 3'b001;
    step();
    chk("regrant_gnt", 32'(gnt), 32'h1);
`else
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("own_unlimited%0d", k), 32'(gnt), 32'h1);
    end
`endif

    // ---- Random run against an arbitration model ----
    req = '0;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_vld = 1'b0;
    m_id  = 0;
    m_ptr = 0;
    for (int c = 0; c < 2000; c++) begin
      int  p;
      bit  f;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      req_data = {10'($urandom), 10'($urandom), 10'($urandom)};
      saved = req_data;
      r     = req;
      step();
      if (!m_vld || !r[m_id]) begin
        p = m_vld ? (m_id + 1) % 3 : m_ptr;
        if (m_vld) m_ptr = p;
        f = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (!f && r[(p + k) % 3]) begin
            f    = 1'b1;
            m_id = (p + k) % 3;
          end
        end
        m_vld = f;
      end
      chk("rand_onehot0", 32'($onehot0(gnt)), 32'h1);
      chk("rand_gnt_vs_vld", 32'(gnt != 3'b000), 32'(owner_vld));
      if (owner_vld)
        chk("rand_ledr", 32'(ledr), 32'(saved[owner_id]));
`ifndef LED_ARB_TIMEOUT_EN
      chk("rand_model_vld", 32'(owner_vld), 32'(m_vld));
      chk("rand_model_id", 32'(owner_id), 32'(m_id));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
